// File: rtl/dap_cmd_dispatch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | dap_cmd_dispatch: decodes the DAP command byte of a buffered request and   |
// | hands the packet to one handler, or answers 0xFF for unknown commands.     |
// | Optional RUN watchdog: define DAP_CMD_TIMEOUT_EN.                          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dap_cmd_dispatch #(
  parameter int unsigned          CMD_NUM        = 8,
  parameter logic [8*CMD_NUM-1:0] CMD_IDS        = 64'h12_10_06_05_03_02_01_00,
  parameter logic [31:0]          TIMEOUT_CYCLES = 32'd1048576
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               i_rx_pkt_valid,
  output logic               o_rx_pkt_done,
  input  logic               i_dap_in_tvalid,
  input  logic [7:0]         i_dap_in_tdata,
  output logic               o_dap_in_tready,
  input  logic [CMD_NUM-1:0] i_handler_tready,
  output logic [CMD_NUM-1:0] o_start,
  input  logic [CMD_NUM-1:0] i_done,
  input  logic [9:0]         i_packet_len,
  output logic [9:0]         o_ram_write_addr,
  output logic [7:0]         o_ram_write_data,
  output logic               o_ram_write_en,
  output logic               o_tx_valid,
  output logic [9:0]         o_tx_len,
  input  logic               i_tx_ready,
  output logic               o_busy,
  output logic               o_timeout
);

  localparam int IDX_W = (CMD_NUM > 1) ? $clog2(CMD_NUM) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DECODE  = 3'd1,
    S_RUN     = 3'd2,
    S_INVALID = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t             r_state;
  logic [7:0]         r_cmd_id;
  logic [IDX_W-1:0]   r_idx;
  logic [CMD_NUM-1:0] r_start;
  logic               r_tx_valid;
  logic [9:0]         r_tx_len;
  logic               r_rx_pkt_done;
  logic               r_ram_write_en;
  logic [7:0]         r_ram_write_data;

  logic               w_hit;
  logic [IDX_W-1:0]   w_hit_idx;
  logic               w_done_hit;

  // Descending scan so the lowest matching handler wins.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = CMD_NUM - 1; i >= 0; i--) begin
      if (CMD_IDS[8*i +: 8] == r_cmd_id) begin
        w_hit     = 1'b1;
        w_hit_idx = IDX_W'(i);
      end
    end
  end

  assign w_done_hit = r_start[r_idx] & i_done[r_idx];

`ifdef DAP_CMD_TIMEOUT_EN
  logic [31:0] r_cnt;
  logic        r_timeout;
  assign o_timeout = r_timeout;
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state          <= S_IDLE;
      r_cmd_id         <= 8'h00;
      r_idx            <= '0;
      r_start          <= '0;
      r_tx_valid       <= 1'b0;
      r_tx_len         <= 10'd0;
      r_rx_pkt_done    <= 1'b0;
      r_ram_write_en   <= 1'b0;
      r_ram_write_data <= 8'h00;
`ifdef DAP_CMD_TIMEOUT_EN
      r_cnt            <= 32'd0;
      r_timeout        <= 1'b0;
`endif
    end else begin
      r_rx_pkt_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Blocked during the release pulse so a stale packet is not re-read.
          if (i_rx_pkt_valid && i_dap_in_tvalid && !r_rx_pkt_done) begin
            r_cmd_id <= i_dap_in_tdata;
            r_state  <= S_DECODE;
          end
        end
        S_DECODE: begin
`ifdef DAP_CMD_TIMEOUT_EN
          r_timeout <= 1'b0;
          r_cnt     <= 32'd0;
`endif
          if (w_hit) begin
            r_idx   <= w_hit_idx;
            r_start <= CMD_NUM'(1) << w_hit_idx;
            r_state <= S_RUN;
          end else begin
            r_ram_write_en   <= 1'b1;
            r_ram_write_data <= 8'hFF;
            r_state          <= S_INVALID;
          end
        end
        S_RUN: begin
          if (w_done_hit) begin
            r_start    <= '0;
            r_tx_len   <= i_packet_len;
            r_tx_valid <= 1'b1;
            r_state    <= S_RESP;
          end
`ifdef DAP_CMD_TIMEOUT_EN
          else if (r_cnt == TIMEOUT_CYCLES - 32'd1) begin
            r_start          <= '0;
            r_timeout        <= 1'b1;
            r_ram_write_en   <= 1'b1;
            r_ram_write_data <= 8'hFF;
            r_state          <= S_INVALID;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
`endif
        end
        S_INVALID: begin
          r_ram_write_en   <= 1'b0;
          r_ram_write_data <= 8'h00;
          r_tx_len         <= 10'd1;
          r_tx_valid       <= 1'b1;
          r_state          <= S_RESP;
        end
        S_RESP: begin
          if (i_tx_ready) begin
            r_tx_valid    <= 1'b0;
            r_rx_pkt_done <= 1'b1;
            r_state       <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_dap_in_tready  = (r_state == S_RUN) & i_handler_tready[r_idx];
  assign o_start          = r_start;
  assign o_rx_pkt_done    = r_rx_pkt_done;
  assign o_ram_write_addr = 10'd0;
  assign o_ram_write_data = r_ram_write_data;
  assign o_ram_write_en   = r_ram_write_en;
  assign o_tx_valid       = r_tx_valid;
  assign o_tx_len         = r_tx_len;
  assign o_busy           = (r_state != S_IDLE);

endmodule
`default_nettype wire
